// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT address scheduler slice.
//   state_t              : scheduler FSM states
//   NTT_LOGN / NTT_BEATS : default stage count (log2 N) and beats per stage
//   KW / IW / PW         : widths of the k, i and p loop indices
package ntt_ctrl_pkg;

  localparam int unsigned NTT_LOGN  = 10;
  localparam int unsigned NTT_BEATS = 64;
  localparam int unsigned KW        = 6;
  localparam int unsigned IW        = 6;
  localparam int unsigned PW        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ntt_addr_scheduler_if.sv
// Handshake bundle between the NTT scheduler and its surroundings.
//   start, hold        : control into the scheduler
//   k, i, p            : loop indices to the address generator
//   addr_valid         : live beat this cycle
//   stage_first/last   : first/last beat of stage p (qualified by addr_valid)
//   busy, done         : run status
// master = scheduler side, slave = controller / address generator side.
interface ntt_addr_scheduler_if;
  import ntt_ctrl_pkg::*;

  logic          start;
  logic          hold;
  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic [PW-1:0] p;
  logic          addr_valid;
  logic          stage_first;
  logic          stage_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, hold,
    output k, i, p, addr_valid, stage_first, stage_last, busy, done
  );

  modport slave (
    output start, hold,
    input  k, i, p, addr_valid, stage_first, stage_last, busy, done
  );

endinterface

// File: rtl/ntt_stage_bounds.sv
// Combinational loop bounds for one NTT stage.
//   p     in  : stage index
//   i_max out : last value of the inner index i
//   k_max out : last value of the outer index k
// Stages 0..2 use i_max=0, k_max=BEATS-1; from stage 3 on the inner loop
// doubles each stage while the outer loop halves, keeping BEATS beats.
module ntt_stage_bounds
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned BEATS = NTT_BEATS
) (
  input  logic [PW-1:0] p,
  output logic [IW-1:0] i_max,
  output logic [KW-1:0] k_max
);

  localparam logic [KW-1:0] K_TOP = KW'(BEATS - 1);

  logic [PW-1:0] shift;

  always_comb begin
    shift = '0;
    i_max = '0;
    k_max = K_TOP;
    if (p >= PW'(3)) begin
      shift = p - PW'(3);
      // (1<<s)-1 expressed as a mask so it stays inside IW bits for s=6
      i_max = ~({IW{1'b1}} << shift);
      k_max = K_TOP >> shift;
    end
  end

endmodule

// File: rtl/ntt_addr_scheduler.sv
// Loop controller for the radix-2, 8-BFU NTT address generator.
// Sweeps stages p=0..NUM_STAGES-1, issuing one (k,i,p) triple per beat
// (i inner, k outer), with DRAIN_CYCLES idle cycles after every stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ntt_addr_scheduler_if.master (start/hold in; k,i,p,
//              addr_valid, stage_first, stage_last, busy, done out)
module ntt_addr_scheduler
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = NTT_LOGN,
  parameter int unsigned BEATS_PER_STG = NTT_BEATS,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ntt_addr_scheduler_if.master bus
);

  // A zero-cycle drain still needs a 1-bit counter to keep the code legal;
  // the DRAIN state is unreachable in that case.
  localparam int unsigned   DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
  localparam logic [PW-1:0] P_LAST     = PW'(NUM_STAGES - 1);

  state_t        state;
  logic [KW-1:0] k_q;
  logic [IW-1:0] i_q;
  logic [PW-1:0] p_q;
  logic [DW-1:0] drain_cnt;
  logic          busy_q;
  logic          done_q;

  logic [IW-1:0] i_max;
  logic [KW-1:0] k_max;
  logic          beat;
  logic          at_i_max;
  logic          at_k_max;

  ntt_stage_bounds #(
    .BEATS (BEATS_PER_STG)
  ) u_bounds (
    .p     (p_q),
    .i_max (i_max),
    .k_max (k_max)
  );

  assign beat     = (state == RUN) & ~bus.hold;
  assign at_i_max = (i_q == i_max);
  assign at_k_max = (k_q == k_max);

  assign bus.k           = k_q;
  assign bus.i           = i_q;
  assign bus.p           = p_q;
  assign bus.addr_valid  = beat;
  assign bus.stage_first = beat & (k_q == '0) & (i_q == '0);
  assign bus.stage_last  = beat & at_i_max & at_k_max;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      i_q       <= '0;
      p_q       <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end

        RUN: begin
          if (!bus.hold) begin
            if (!at_i_max) begin
              i_q <= i_q + IW'(1);
            end else if (!at_k_max) begin
              i_q <= '0;
              k_q <= k_q + KW'(1);
            end else if (DRAIN_CYCLES != 0) begin
              // indices keep the last-issued beat until the drain ends
              state     <= DRAIN;
              drain_cnt <= '0;
            end else if (p_q != P_LAST) begin
              p_q <= p_q + PW'(1);
              k_q <= '0;
              i_q <= '0;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (p_q != P_LAST) begin
              state <= RUN;
              p_q   <= p_q + PW'(1);
              k_q   <= '0;
              i_q   <= '0;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          k_q    <= '0;
          i_q    <= '0;
          p_q    <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_scheduler.sv
// Scoreboard bench for ntt_addr_scheduler: one instance with no drain gap,
// one with a 4-cycle drain gap.
module tb_ntt_addr_scheduler;
  import ntt_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_addr_scheduler_if bus0 ();
  ntt_addr_scheduler_if bus4 ();

  ntt_addr_scheduler #(
    .NUM_STAGES    (10),
    .BEATS_PER_STG (64),
    .DRAIN_CYCLES  (0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  ntt_addr_scheduler #(
    .NUM_STAGES    (10),
    .BEATS_PER_STG (64),
    .DRAIN_CYCLES  (4)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  typedef struct packed {
    logic [5:0] k;
    logic [5:0] i;
    logic [3:0] p;
    logic       first;
    logic       last;
  } beat_t;

  beat_t q0[$];
  beat_t q4[$];

  int n_chk  = 0;
  int n_fail = 0;

  int t0        [2];
  int beats     [2];
  int first_cyc [2];
  int last_cyc  [2];
  int done_cyc  [2];
  int done_n    [2];
  int busy_pre  [2];
  int prev_last [2];
  int firsts    [2][16];
  int lasts     [2][16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic clear_stats(input int d);
    t0[d]        = cyc;
    beats[d]     = 0;
    first_cyc[d] = 0;
    last_cyc[d]  = 0;
    done_cyc[d]  = 0;
    done_n[d]    = 0;
    busy_pre[d]  = 0;
    prev_last[d] = 0;
    for (int s = 0; s < 16; s++) begin
      firsts[d][s] = 0;
      lasts[d][s]  = 0;
    end
  endtask

  // Expected beat order: stage-wise nested loops, i inner, k outer.
  task automatic push_run(input int d);
    beat_t b;
    for (int pp = 0; pp < 10; pp++) begin
      int ni;
      int nk;
      ni = (pp < 3) ? 1 : (1 << (pp - 3));
      nk = 64 / ni;
      for (int kk = 0; kk < nk; kk++) begin
        for (int ii = 0; ii < ni; ii++) begin
          b.k     = 6'(kk);
          b.i     = 6'(ii);
          b.p     = 4'(pp);
          b.first = (kk == 0) && (ii == 0);
          b.last  = (kk == nk - 1) && (ii == ni - 1);
          if (d == 0) q0.push_back(b);
          else        q4.push_back(b);
        end
      end
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [5:0] k, input logic [5:0] i,
                     input logic [3:0] p, input logic f, input logic l,
                     input logic bsy, input logic dn);
    beat_t ab;
    beat_t eb;
    int rel;
    rel = cyc - t0[d];
    if (bsy === 1'b1 && dn !== 1'b1) busy_pre[d]++;
    if (dn === 1'b1) begin
      done_n[d]++;
      done_cyc[d] = rel;
      if (d == 1) chk("tail_drain_gap", 32'(rel - prev_last[d] - 1), 4);
    end
    if (v === 1'b1) begin
      ab.k = k; ab.i = i; ab.p = p; ab.first = f; ab.last = l;
      beats[d]++;
      if (beats[d] == 1) first_cyc[d] = rel;
      last_cyc[d] = rel;
      if (f === 1'b1) begin
        firsts[d][p]++;
        if (d == 1 && p != 4'd0) chk("stage_drain_gap", 32'(rel - prev_last[d] - 1), 4);
      end
      if (l === 1'b1) begin
        lasts[d][p]++;
        prev_last[d] = rel;
      end
      if ((d == 0 ? q0.size() : q4.size()) == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat dut%0d: got %0h expected no beat", d, ab);
      end else begin
        eb = (d == 0) ? q0.pop_front() : q4.pop_front();
        chk(d == 0 ? "beat_dut0" : "beat_dut4", 32'(ab), 32'(eb));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.addr_valid, bus0.k, bus0.i, bus0.p, bus0.stage_first, bus0.stage_last,
        bus0.busy, bus0.done);
    mon(1, bus4.addr_valid, bus4.k, bus4.i, bus4.p, bus4.stage_first, bus4.stage_last,
        bus4.busy, bus4.done);
  end

  task automatic start_run(input int d);
    @(posedge clk); #1;
    clear_stats(d);
    if (d == 0) bus0.start = 1'b1;
    else        bus4.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  task automatic wait_rel(input int d, input int r);
    while (cyc - t0[d] < r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int d, input int limit);
    int n;
    n = 0;
    while (done_n[d] == 0 && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_n[d] == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout dut%0d: got no done expected done within %0d cycles", d, limit);
    end
  endtask

  task automatic check_run(input int d, input int e_last, input int e_done, input int e_busy);
    int ok_stages;
    ok_stages = 0;
    @(negedge clk);
    chk("busy_after_done", (d == 0) ? bus0.busy : bus4.busy, 0);
    chk("beat_count", beats[d], 640);
    chk("first_beat_cycle", first_cyc[d], 1);
    chk("last_beat_cycle", last_cyc[d], e_last);
    chk("done_cycle", done_cyc[d], e_done);
    chk("done_pulses", done_n[d], 1);
    chk("busy_cycles_before_done", busy_pre[d], e_busy);
    for (int s = 0; s < 10; s++)
      if (firsts[d][s] == 1 && lasts[d][s] == 1) ok_stages++;
    chk("stages_with_one_first_last", ok_stages, 10);
    chk("leftover_expected", (d == 0) ? q0.size() : q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.start = 1'b0; bus0.hold = 1'b0;
    bus4.start = 1'b0; bus4.hold = 1'b0;
    clear_stats(0);
    clear_stats(1);

    // reset with random start/hold
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus0.start = 1'($urandom_range(0, 1));
      bus0.hold  = 1'($urandom_range(0, 1));
      bus4.start = 1'($urandom_range(0, 1));
      bus4.hold  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_outputs_dut0", {bus0.k, bus0.i, bus0.p, bus0.addr_valid, bus0.stage_first,
                                 bus0.stage_last, bus0.busy, bus0.done}, 0);
      chk("reset_outputs_dut4", {bus4.k, bus4.i, bus4.p, bus4.addr_valid, bus4.stage_first,
                                 bus4.stage_last, bus4.busy, bus4.done}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.start = 1'b0; bus0.hold = 1'b0;
    bus4.start = 1'b0; bus4.hold = 1'b0;

    // full sweep, no drain: beats on cycles 1..640, done on 641
    push_run(0);
    start_run(0);
    wait_done(0, 1000);
    check_run(0, 640, 641, 640);

    // hold for 3 cycles at beat 10 of p=4 (cycle 267): k=5, i=0 frozen
    push_run(0);
    start_run(0);
    wait_rel(0, 267);
    bus0.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", bus0.addr_valid, 0);
      chk("hold_kip", {bus0.k, bus0.i, bus0.p}, {6'd5, 6'd0, 4'd4});
      @(posedge clk); #1;
    end
    bus0.hold = 1'b0;
    wait_done(0, 1000);
    check_run(0, 643, 644, 643);

    // 4-cycle drain: last beat on 676, done on 681
    push_run(1);
    start_run(1);
    wait_done(1, 1000);
    check_run(1, 676, 681, 680);

    // abuse: start during p=6, reset at beat 20 of p=7 (cycle 469)
    push_run(0);
    start_run(0);
    wait_rel(0, 385);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    wait_rel(0, 469);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("beats_before_rst", beats[0], 469);
    q0.delete();
    @(negedge clk);
    chk("rst_midrun_outputs", {bus0.k, bus0.i, bus0.p, bus0.addr_valid, bus0.stage_first,
                               bus0.stage_last, bus0.busy, bus0.done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_run(0);
    start_run(0);
    wait_done(0, 1000);
    check_run(0, 640, 641, 640);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
